async_mmap_read_arbiter: RTL and testbench

//   Shares one async_mmap read channel among NumPorts requesters. Round-robin

---
 rtl/async_mmap_read_arbiter.sv | 156 +++++++++++++++
 tb/tb_async_mmap_read_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_mmap_read_arbiter.sv
// Purpose: round-robin share of one async_mmap read channel among NumPorts requesters, data routed back in issue order.
// Latency: address accepted in cycle 0 appears on read_addr in cycle 2; one address per cycle sustained.
// Backpressure: read_addr_full_n stalls the output register; a full order FIFO stalls issue; the head port holds all responses.
module async_mmap_read_arbiter #(
  parameter int NumPorts      = 4,
  parameter int PortIdWidth   = 2,
  parameter int AddrWidth     = 64,
  parameter int DataWidth     = 512,
  parameter int OrderDepth    = 32,
  parameter int OrderDepthLog = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumPorts*AddrWidth-1:0] req_addr_din,
  input  logic [NumPorts-1:0]           req_addr_write,
  output logic [NumPorts-1:0]           req_addr_full_n,
  output logic [DataWidth-1:0]          req_data_dout,
  input  logic [NumPorts-1:0]           req_data_read,
  output logic [NumPorts-1:0]           req_data_empty_n,
  output logic [AddrWidth-1:0]          read_addr_din,
  output logic                          read_addr_write,
  input  logic                          read_addr_full_n,
  input  logic [DataWidth-1:0]          read_data_dout,
  output logic                          read_data_read,
  input  logic                          read_data_empty_n
);

  localparam int CntW = OrderDepthLog + 1;

  // Per-port two-entry address buffers.
  logic [AddrWidth-1:0]   buf_mem [NumPorts][2];
  logic [NumPorts-1:0]    buf_wr_ptr;
  logic [NumPorts-1:0]    buf_rd_ptr;
  logic [1:0]             buf_cnt [NumPorts];
  logic [1:0]             buf_cnt_nxt [NumPorts];
  logic [NumPorts-1:0]    buf_push;
  logic [NumPorts-1:0]    buf_pop;
  logic [NumPorts-1:0]    full_n_q;

  // Output register and arbiter state.
  logic                   out_valid;
  logic [AddrWidth-1:0]   out_addr;
  logic [PortIdWidth-1:0] out_id;
  logic [PortIdWidth-1:0] rr_ptr;
  logic                   cand_found;
  logic [PortIdWidth-1:0] cand_id;
  logic [PortIdWidth-1:0] idx;
  logic                   load;
  logic                   issue;

  // Order FIFO of granted port ids.
  logic [PortIdWidth-1:0]   order_mem [OrderDepth];
  logic [OrderDepthLog-1:0] order_wr;
  logic [OrderDepthLog-1:0] order_rd;
  logic [CntW-1:0]          order_cnt;
  logic [PortIdWidth-1:0]   order_head;
  logic                     order_nonempty;
  logic                     order_full;

  assign req_addr_full_n = full_n_q;
  assign order_nonempty  = (order_cnt != '0);
  assign order_full      = (order_cnt == CntW'(OrderDepth));
  assign order_head      = order_mem[order_rd];
  assign issue           = out_valid & read_addr_full_n & ~order_full;
  assign read_addr_write = issue;
  assign read_addr_din   = out_addr;
  assign req_data_dout   = read_data_dout;
  assign load            = (~out_valid | issue) & cand_found;

  // Round-robin search starting just after the last winner; also derives buffer pops and next counts.
  always_comb begin
    cand_found = 1'b0;
    cand_id    = '0;
    idx        = '0;
    for (int k = 1; k <= NumPorts; k++) begin
      idx = PortIdWidth'((int'(rr_ptr) + k) % NumPorts);
      if (!cand_found && buf_cnt[idx] != 2'd0) begin
        cand_found = 1'b1;
        cand_id    = idx;
      end
    end
    for (int i = 0; i < NumPorts; i++) begin
      buf_push[i]    = req_addr_write[i] & full_n_q[i];
      buf_pop[i]     = load && (cand_id == PortIdWidth'(i));
      buf_cnt_nxt[i] = buf_cnt[i] + 2'(buf_push[i]) - 2'(buf_pop[i]);
    end
  end

  // Buffer pointers, occupancy and the registered not-full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_wr_ptr <= '0;
      buf_rd_ptr <= '0;
      full_n_q   <= '1;
      for (int i = 0; i < NumPorts; i++) buf_cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        if (buf_push[i]) buf_wr_ptr[i] <= ~buf_wr_ptr[i];
        if (buf_pop[i])  buf_rd_ptr[i] <= ~buf_rd_ptr[i];
        buf_cnt[i]  <= buf_cnt_nxt[i];
        full_n_q[i] <= (buf_cnt_nxt[i] != 2'd2);
      end
    end
  end

  // Buffer storage; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumPorts; i++) begin
      if (buf_push[i]) buf_mem[i][buf_wr_ptr[i]] <= req_addr_din[i*AddrWidth +: AddrWidth];
    end
  end

  // Output register: reload when empty or draining, otherwise hold addr/id steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_id    <= '0;
      rr_ptr    <= PortIdWidth'(NumPorts - 1);
    end else if (load) begin
      out_valid <= 1'b1;
      out_addr  <= buf_mem[cand_id][buf_rd_ptr[cand_id]];
      out_id    <= cand_id;
      rr_ptr    <= cand_id;
    end else if (issue) begin
      out_valid <= 1'b0;
    end
  end

  // Order FIFO pointers and count; push on issue, pop on delivered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_wr  <= '0;
      order_rd  <= '0;
      order_cnt <= '0;
    end else begin
      if (issue)          order_wr <= order_wr + 1'b1;
      if (read_data_read) order_rd <= order_rd + 1'b1;
      order_cnt <= order_cnt + CntW'(issue) - CntW'(read_data_read);
    end
  end

  // Order FIFO storage.
  always_ff @(posedge clk) begin
    if (issue) order_mem[order_wr] <= out_id;
  end

  // Only the head port sees data; other ports wait behind it.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      req_data_empty_n[i] = read_data_empty_n & order_nonempty & (order_head == PortIdWidth'(i));
    end
    read_data_read = req_data_read[order_head] & req_data_empty_n[order_head];
  end

endmodule

// File: tb/tb_async_mmap_read_arbiter.sv
module tb_async_mmap_read_arbiter;

  localparam int NP = 4;
  localparam int AW = 64;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NP*AW-1:0] req_addr_din;
  logic [NP-1:0]   req_addr_write;
  logic [NP-1:0]   req_addr_full_n;
  logic [DW-1:0]   req_data_dout;
  logic [NP-1:0]   req_data_read;
  logic [NP-1:0]   req_data_empty_n;
  logic [AW-1:0]   read_addr_din;
  logic            read_addr_write;
  logic            read_addr_full_n;
  logic [DW-1:0]   read_data_dout;
  logic            read_data_read;
  logic            read_data_empty_n;

  async_mmap_read_arbiter #(
    .NumPorts(4), .PortIdWidth(2), .AddrWidth(AW), .DataWidth(DW),
    .OrderDepth(4), .OrderDepthLog(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr_din(req_addr_din), .req_addr_write(req_addr_write), .req_addr_full_n(req_addr_full_n),
    .req_data_dout(req_data_dout), .req_data_read(req_data_read), .req_data_empty_n(req_data_empty_n),
    .read_addr_din(read_addr_din), .read_addr_write(read_addr_write), .read_addr_full_n(read_addr_full_n),
    .read_data_dout(read_data_dout), .read_data_read(read_data_read), .read_data_empty_n(read_data_empty_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc;
  int push_rem [NP];
  int seq [NP];
  int acc [NP];
  logic [NP-1:0] rd_en;
  bit mmap_en;
  bit ds_rdy;
  logic [AW-1:0] port_q [NP][$];
  logic [AW-1:0] mq [$];
  int issued_ports [$];
  int issue_cyc [$];
  int delivered_ports [$];
  int n_issue;

  logic          obs_write;
  logic [AW-1:0] obs_din;
  logic          obs_rd;
  logic [NP-1:0] obs_empty_n;
  logic [NP-1:0] obs_full_n;

  function automatic logic [AW-1:0] addr_of(int p, int s);
    logic [AW-1:0] a;
    a = AW'(s) << 6;
    a[33:32] = 2'(p);
    return a;
  endfunction

  function automatic logic [DW-1:0] data_of(logic [AW-1:0] a);
    return {8{a ^ 64'hA5A5_0000_0000_0000}};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NP; i++) begin
      push_rem[i] = 0; seq[i] = 0; acc[i] = 0; port_q[i].delete();
    end
    mq.delete(); issued_ports.delete(); issue_cyc.delete(); delivered_ports.delete();
    n_issue = 0; rd_en = '0; mmap_en = 0; ds_rdy = 1; cyc = 0;
    req_addr_write = '0; req_addr_din = '0; req_data_read = '0;
    read_addr_full_n = 1'b1; read_data_empty_n = 1'b0; read_data_dout = '0;
  endtask

  // One clock cycle: drive from the model, observe, update scoreboard, advance to next negedge.
  task automatic tick();
    logic [AW-1:0] e;
    int p;
    for (int i = 0; i < NP; i++) begin
      req_addr_write[i] = (push_rem[i] > 0);
      req_addr_din[i*AW +: AW] = addr_of(i, seq[i]);
    end
    req_data_read = rd_en;
    read_addr_full_n = ds_rdy;
    read_data_empty_n = mmap_en && (mq.size() > 0);
    read_data_dout = (mq.size() > 0) ? data_of(mq[0]) : '0;
    #1;
    obs_write = read_addr_write; obs_din = read_addr_din; obs_rd = read_data_read;
    obs_empty_n = req_data_empty_n; obs_full_n = req_addr_full_n;
    for (int i = 0; i < NP; i++) begin
      if (req_addr_write[i] && req_addr_full_n[i]) begin
        port_q[i].push_back(addr_of(i, seq[i]));
        seq[i]++; push_rem[i]--; acc[i]++;
      end
    end
    if (obs_rd) begin
      total++;
      if (mq.size() == 0) begin
        bad++; $display("FAIL spurious_read: read_data_read=1 but no beat pending");
      end else begin
        e = mq.pop_front();
        p = int'(e[33:32]);
        if (obs_empty_n !== 4'(1 << p)) begin
          bad++; $display("FAIL deliver_port: empty_n=%b want %b", obs_empty_n, 4'(1 << p));
        end
        total++;
        if (req_data_dout !== data_of(e)) begin
          bad++; $display("FAIL deliver_data: got %0h want %0h", req_data_dout[63:0], data_of(e)[63:0]);
        end
        delivered_ports.push_back(p);
      end
    end
    if (obs_write) begin
      p = int'(obs_din[33:32]);
      issued_ports.push_back(p); issue_cyc.push_back(cyc); n_issue++;
      total++;
      if (port_q[p].size() == 0) begin
        bad++; $display("FAIL issue_unexpected: addr %0h not pending", obs_din);
      end else begin
        e = port_q[p].pop_front();
        if (obs_din !== e) begin
          bad++; $display("FAIL issue_addr: got %0h want %0h", obs_din, e);
        end
      end
      mq.push_back(obs_din);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(int limit);
    int n;
    bit busy;
    n = 0;
    busy = 1;
    while (busy && n < limit) begin
      busy = (mq.size() != 0);
      for (int i = 0; i < NP; i++) if (push_rem[i] != 0 || port_q[i].size() != 0) busy = 1;
      if (busy) begin tick(); n++; end
    end
    total++;
    if (busy) begin
      bad++; $display("FAIL drain_timeout: still busy after %0d cycles (mq=%0d)", n, mq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    read_data_empty_n = 1'b1;
    req_data_read = '1;
    #1;
    total++; if (req_addr_full_n !== 4'b1111) begin bad++; $display("FAIL rst_full_n: got %b want 1111", req_addr_full_n); end
    total++; if (read_addr_write !== 1'b0) begin bad++; $display("FAIL rst_write: got %b want 0", read_addr_write); end
    total++; if (req_data_empty_n !== 4'b0000) begin bad++; $display("FAIL rst_empty_n: got %b want 0000", req_data_empty_n); end
    total++; if (read_data_read !== 1'b0) begin bad++; $display("FAIL rst_read: got %b want 0", read_data_read); end
    apply_reset();
    tick();
    total++; if (obs_write !== 1'b0) begin bad++; $display("FAIL idle_write: got %b want 0", obs_write); end
  endtask

  task automatic test_single_port();
    apply_reset();
    rd_en = 4'b0001; mmap_en = 1; push_rem[0] = 8;
    drain(60);
    total++; if (issue_cyc.size() != 8) begin bad++; $display("FAIL sp_issue_count: got %0d want 8", issue_cyc.size()); end
    for (int k = 0; k < issue_cyc.size(); k++) begin
      total++;
      if (issue_cyc[k] != 2 + k) begin bad++; $display("FAIL sp_issue_cycle[%0d]: got %0d want %0d", k, issue_cyc[k], 2 + k); end
    end
    total++; if (delivered_ports.size() != 8) begin bad++; $display("FAIL sp_deliver_count: got %0d want 8", delivered_ports.size()); end
    for (int k = 0; k < delivered_ports.size(); k++) begin
      total++;
      if (delivered_ports[k] != 0) begin bad++; $display("FAIL sp_deliver_port[%0d]: got %0d want 0", k, delivered_ports[k]); end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    rd_en = 4'b1111; mmap_en = 1;
    for (int i = 0; i < NP; i++) push_rem[i] = 4;
    drain(100);
    total++; if (issued_ports.size() != 16) begin bad++; $display("FAIL rr_issue_count: got %0d want 16", issued_ports.size()); end
    for (int k = 0; k < issued_ports.size(); k++) begin
      total++;
      if (issued_ports[k] != k % 4) begin bad++; $display("FAIL rr_issue_id[%0d]: got %0d want %0d", k, issued_ports[k], k % 4); end
    end
    for (int k = 0; k < delivered_ports.size(); k++) begin
      total++;
      if (delivered_ports[k] != k % 4) begin bad++; $display("FAIL rr_deliver[%0d]: got %0d want %0d", k, delivered_ports[k], k % 4); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rd_en = 4'b1111; mmap_en = 1; ds_rdy = 0;
    for (int i = 0; i < NP; i++) push_rem[i] = 4;
    tick(); tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (obs_write !== 1'b0 || obs_din !== 64'h0) begin
        bad++; $display("FAIL bp_stable[%0d]: write=%b din=%0h want 0/0", k, obs_write, obs_din);
      end
    end
    for (int i = 0; i < NP; i++) begin
      total++;
      if (acc[i] != ((i == 0) ? 3 : 2)) begin bad++; $display("FAIL bp_accepted[%0d]: got %0d want %0d", i, acc[i], (i == 0) ? 3 : 2); end
    end
    total++; if (obs_full_n !== 4'b0000) begin bad++; $display("FAIL bp_full_n: got %b want 0000", obs_full_n); end
    ds_rdy = 1;
    drain(150);
    total++; if (n_issue != 16) begin bad++; $display("FAIL bp_issue_total: got %0d want 16", n_issue); end
    total++; if (delivered_ports.size() != 16) begin bad++; $display("FAIL bp_deliver_total: got %0d want 16", delivered_ports.size()); end
  endtask

  task automatic test_order_full();
    apply_reset();
    rd_en = 4'b0001; mmap_en = 0; push_rem[0] = 8;
    repeat (12) tick();
    total++; if (n_issue != 4) begin bad++; $display("FAIL of_issue_cap: got %0d want 4", n_issue); end
    total++; if (obs_write !== 1'b0) begin bad++; $display("FAIL of_write_low: got %b want 0", obs_write); end
    mmap_en = 1;
    tick();
    mmap_en = 0;
    total++; if (obs_rd !== 1'b1 || obs_write !== 1'b0) begin bad++; $display("FAIL of_pop: rd=%b write=%b want 1/0", obs_rd, obs_write); end
    tick();
    total++; if (obs_write !== 1'b1 || n_issue != 5) begin bad++; $display("FAIL of_one_more: write=%b issues=%0d want 1/5", obs_write, n_issue); end
    repeat (4) tick();
    total++; if (n_issue != 5) begin bad++; $display("FAIL of_hold: got %0d want 5", n_issue); end
    mmap_en = 1;
    drain(100);
    total++; if (n_issue != 8) begin bad++; $display("FAIL of_issue_total: got %0d want 8", n_issue); end
  endtask

  task automatic test_head_of_line();
    apply_reset();
    rd_en = 4'b0100; mmap_en = 1; push_rem[1] = 1; push_rem[2] = 1;
    repeat (4) tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (obs_rd !== 1'b0 || obs_empty_n !== 4'b0010) begin
        bad++; $display("FAIL hol_block[%0d]: rd=%b empty_n=%b want 0/0010", k, obs_rd, obs_empty_n);
      end
    end
    rd_en = 4'b0110;
    tick();
    total++; if (obs_rd !== 1'b1) begin bad++; $display("FAIL hol_release: got %b want 1", obs_rd); end
    tick();
    total++; if (obs_empty_n !== 4'b0100 || obs_rd !== 1'b1) begin bad++; $display("FAIL hol_next: empty_n=%b rd=%b want 0100/1", obs_empty_n, obs_rd); end
    drain(30);
    total++;
    if (delivered_ports.size() != 2 || delivered_ports[0] != 1 || delivered_ports[1] != 2) begin
      bad++; $display("FAIL hol_order: got %0d beats, want ports 1 then 2", delivered_ports.size());
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    rd_en = 4'b1111; mmap_en = 1;
    for (int i = 0; i < NP; i++) push_rem[i] = 4;
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (req_addr_full_n !== 4'b1111) begin bad++; $display("FAIL mr_full_n: got %b want 1111", req_addr_full_n); end
    total++; if (read_addr_write !== 1'b0) begin bad++; $display("FAIL mr_write: got %b want 0", read_addr_write); end
    total++; if (req_data_empty_n !== 4'b0000) begin bad++; $display("FAIL mr_empty_n: got %b want 0000", req_data_empty_n); end
    total++; if (read_data_read !== 1'b0) begin bad++; $display("FAIL mr_read: got %b want 0", read_data_read); end
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = 4'b1111; mmap_en = 1;
    for (int i = 0; i < NP; i++) push_rem[i] = 1;
    drain(40);
    total++;
    if (issued_ports.size() == 0 || issued_ports[0] != 0) begin
      bad++; $display("FAIL mr_first_grant: got %0d want port 0", (issued_ports.size() == 0) ? -1 : issued_ports[0]);
    end
  endtask

  initial begin
    clear_model();
    #2;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_order_full();
    test_head_of_line();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
